// File: rtl/rx_frame_chk.sv
// UART receive-frame sequencer: walks start/data/parity/stop bits from the voted sampler,
// flags start glitches, parity and framing errors, and emits good words with a valid pulse.
module rx_frame_chk #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  edge_det,
  input  logic                  bit_vld,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_vld,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop1, StStop2} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic                    par_acc_q;
  logic                    bad_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    stop2_q;

  assign busy = (state_q != StIdle);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shreg_q     <= '0;
      par_acc_q   <= 1'b0;
      bad_q       <= 1'b0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      stop2_q     <= 1'b0;
      data_out    <= '0;
      data_vld    <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_vld    <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      case (state_q)
        StIdle: begin
          // bit_vld is deliberately ignored here, even when coincident with edge_det
          if (edge_det) begin
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            stop2_q   <= stop2;
            cnt_q     <= '0;
            par_acc_q <= 1'b0;
            bad_q     <= 1'b0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (bit_vld) begin
            if (sampled_bit) begin
              strt_glitch <= 1'b1;
              state_q     <= StIdle;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (bit_vld) begin
            shreg_q   <= {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
            par_acc_q <= par_acc_q ^ sampled_bit;
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              state_q <= par_en_q ? StParity : StStop1;
            end
          end
        end
        StParity: begin
          if (bit_vld) begin
            if (sampled_bit != (par_acc_q ^ par_typ_q)) begin
              par_err <= 1'b1;
              bad_q   <= 1'b1;
            end
            state_q <= StStop1;
          end
        end
        StStop1: begin
          if (bit_vld) begin
            if (!sampled_bit) begin
              stp_err <= 1'b1;
              state_q <= StIdle;
            end else if (stop2_q) begin
              state_q <= StStop2;
            end else begin
              if (!bad_q) begin
                data_out <= shreg_q;
                data_vld <= 1'b1;
              end
              state_q <= StIdle;
            end
          end
        end
        StStop2: begin
          if (bit_vld) begin
            if (!sampled_bit) begin
              stp_err <= 1'b1;
            end else if (!bad_q) begin
              data_out <= shreg_q;
              data_vld <= 1'b1;
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_chk.sv
// Directed bench for rx_frame_chk: 8-bit instance for the main scenarios, 5-bit instance
// for back-to-back sampling with edge_det coincident with bit_vld.
module tb_rx_frame_chk;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic edge_det = 1'b0;
  logic bit_vld = 1'b0;
  logic sampled_bit = 1'b0;
  logic par_en = 1'b0;
  logic par_typ = 1'b0;
  logic stop2 = 1'b0;

  logic [7:0] data_out;
  logic       data_vld, strt_glitch, par_err, stp_err, busy;
  logic [4:0] data_out5;
  logic       data_vld5, strt_glitch5, par_err5, stp_err5, busy5;

  int tests = 0;
  int fails = 0;
  int n_vld = 0, n_glitch = 0, n_perr = 0, n_serr = 0;

  always #5 CLK = ~CLK;

  rx_frame_chk #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .edge_det(edge_det), .bit_vld(bit_vld), .sampled_bit(sampled_bit),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .data_out(data_out),
    .data_vld(data_vld), .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .busy(busy)
  );

  rx_frame_chk #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .edge_det(edge_det), .bit_vld(bit_vld), .sampled_bit(sampled_bit),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .data_out(data_out5),
    .data_vld(data_vld5), .strt_glitch(strt_glitch5), .par_err(par_err5), .stp_err(stp_err5),
    .busy(busy5)
  );

  // Pulse counters for the 8-bit instance, sampled mid-cycle
  always @(negedge CLK) begin
    if (data_vld)    n_vld++;
    if (strt_glitch) n_glitch++;
    if (par_err)     n_perr++;
    if (stp_err)     n_serr++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_edge();
    edge_det = 1'b1;
    tick();
    edge_det = 1'b0;
  endtask

  // Sends bits[0] first; gap idle cycles precede every bit after the first
  task automatic send_bits(input logic [15:0] bits, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i != 0) repeat (gap) tick();
      bit_vld     = 1'b1;
      sampled_bit = bits[i];
      tick();
      bit_vld     = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) tick();
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out got %0h want 0", data_out); end
    tests++; if ({data_vld, strt_glitch, par_err, stp_err, busy} !== 5'b0) begin
      fails++; $display("FAIL reset_flags got %b want 00000", {data_vld, strt_glitch, par_err, stp_err, busy});
    end
    @(negedge CLK) RST = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    int v0 = n_vld;
    int e0 = n_glitch + n_perr + n_serr;
    par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
    pulse_edge();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL good_busy_rise got %b want 1", busy); end
    send_bits({5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1);
    tests++; if (data_vld !== 1'b1) begin fails++; $display("FAIL good_vld got %b want 1", data_vld); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL good_busy_fall got %b want 0", busy); end
    tests++; if (data_out !== 8'hA5) begin fails++; $display("FAIL good_data got %0h want a5", data_out); end
    tick();
    tests++; if (data_vld !== 1'b0) begin fails++; $display("FAIL good_vld_width got %b want 0", data_vld); end
    tests++; if (n_vld - v0 !== 1) begin fails++; $display("FAIL good_vld_count got %0d want 1", n_vld - v0); end
    tests++; if (n_glitch + n_perr + n_serr - e0 !== 0) begin
      fails++; $display("FAIL good_no_err got %0d want 0", n_glitch + n_perr + n_serr - e0);
    end
  endtask

  task automatic test_glitch();
    int g0 = n_glitch;
    pulse_edge();
    send_bits(16'h0001, 1, 0);
    tests++; if (strt_glitch !== 1'b1) begin fails++; $display("FAIL glitch_pulse got %b want 1", strt_glitch); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy got %b want 0", busy); end
    tests++; if (data_out !== 8'hA5) begin fails++; $display("FAIL glitch_data_hold got %0h want a5", data_out); end
    tick();
    tests++; if (n_glitch - g0 !== 1) begin fails++; $display("FAIL glitch_count got %0d want 1", n_glitch - g0); end
    pulse_edge();
    send_bits({5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 1);
    tests++; if (data_vld !== 1'b1 || data_out !== 8'h3C) begin
      fails++; $display("FAIL glitch_next_frame got vld=%b data=%0h want vld=1 data=3c", data_vld, data_out);
    end
    tick();
  endtask

  task automatic test_parity_err();
    int v0, p0;
    par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b0;
    pulse_edge();
    send_bits({5'b0, 1'b1, 1'b1, 8'h66, 1'b0}, 11, 1);
    tests++; if (data_out !== 8'h66) begin fails++; $display("FAIL odd_par_good got %0h want 66", data_out); end
    tick();
    v0 = n_vld; p0 = n_perr;
    pulse_edge();
    par_typ = 1'b0;  // mid-frame config change must not matter
    send_bits({6'b0, 1'b0, 8'h3C, 1'b0}, 10, 1);
    tests++; if (par_err !== 1'b1) begin fails++; $display("FAIL par_err_pulse got %b want 1", par_err); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL par_err_busy got %b want 1", busy); end
    tick();
    send_bits(16'h0001, 1, 0);
    tests++; if (data_vld !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL par_err_end got vld=%b busy=%b want vld=0 busy=0", data_vld, busy);
    end
    tests++; if (data_out !== 8'h66) begin fails++; $display("FAIL par_err_hold got %0h want 66", data_out); end
    tick();
    tests++; if (n_perr - p0 !== 1 || n_vld - v0 !== 0) begin
      fails++; $display("FAIL par_err_counts got perr=%0d vld=%0d want 1 0", n_perr - p0, n_vld - v0);
    end
  endtask

  task automatic test_stop2();
    int v0 = n_vld;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b1;
    pulse_edge();
    send_bits({5'b0, 1'b0, 1'b1, 8'h81, 1'b0}, 11, 1);
    tests++; if (stp_err !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL stop2_err got serr=%b busy=%b want 1 0", stp_err, busy);
    end
    tests++; if (data_out !== 8'h66 || n_vld - v0 !== 0) begin
      fails++; $display("FAIL stop2_discard got data=%0h vld=%0d want 66 0", data_out, n_vld - v0);
    end
    tick();
    pulse_edge();
    send_bits({5'b0, 1'b1, 1'b1, 8'h81, 1'b0}, 11, 1);
    tests++; if (data_vld !== 1'b1 || data_out !== 8'h81 || stp_err !== 1'b0) begin
      fails++; $display("FAIL stop2_good got vld=%b data=%0h serr=%b want 1 81 0", data_vld, data_out, stp_err);
    end
    tick();
    stop2 = 1'b0;
    pulse_edge();
    send_bits({6'b0, 1'b0, 8'h42, 1'b0}, 10, 1);
    tests++; if (stp_err !== 1'b1 || data_out !== 8'h81) begin
      fails++; $display("FAIL stop1_err got serr=%b data=%0h want 1 81", stp_err, data_out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    par_en = 1'b0; stop2 = 1'b0;
    pulse_edge();
    send_bits(16'b0110, 4, 1);
    tick();
    bit_vld = 1'b1; sampled_bit = 1'b1;
    #2 RST = 1'b0;
    #1;
    tests++; if (data_out !== 8'h00 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_reset got data=%0h busy=%b want 0 0", data_out, busy);
    end
    @(negedge CLK) begin RST = 1'b1; bit_vld = 1'b0; end
    tick();
    tests++; if ({data_vld, strt_glitch, par_err, stp_err, busy} !== 5'b0) begin
      fails++; $display("FAIL mid_reset_quiet got %b want 00000", {data_vld, strt_glitch, par_err, stp_err, busy});
    end
    pulse_edge();
    send_bits({6'b0, 1'b1, 8'h5A, 1'b0}, 10, 1);
    tests++; if (data_vld !== 1'b1 || data_out !== 8'h5A) begin
      fails++; $display("FAIL mid_reset_next got vld=%b data=%0h want 1 5a", data_vld, data_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    RST = 1'b0;
    tick();
    @(negedge CLK) RST = 1'b1;
    tick();
    par_en = 1'b0; stop2 = 1'b0;
    // edge_det with a high bit_vld in IDLE: the sample must not be taken as the start bit
    edge_det = 1'b1; bit_vld = 1'b1; sampled_bit = 1'b1;
    tick();
    edge_det = 1'b0;
    send_bits({9'b0, 1'b1, 5'h15, 1'b0}, 7, 0);
    tests++; if (data_vld5 !== 1'b1 || data_out5 !== 5'h15) begin
      fails++; $display("FAIL b2b_w5 got vld=%b data=%0h want 1 15", data_vld5, data_out5);
    end
    tests++; if (strt_glitch5 !== 1'b0 || busy5 !== 1'b0) begin
      fails++; $display("FAIL b2b_w5_flags got glitch=%b busy=%b want 0 0", strt_glitch5, busy5);
    end
    tick();
    tests++; if (data_vld5 !== 1'b0) begin fails++; $display("FAIL b2b_w5_vld_width got %b want 0", data_vld5); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_parity_err();
    test_stop2();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_frame_chk.md
# rx_frame_chk

Parametrised receive-frame checker for the UART RX path. It takes one majority-voted bit per bit period from the RX sampler and walks a full frame: start bit, DATA_WIDTH data bits, optional parity, one or two stop bits. It flags start glitches, parity errors and stop (framing) errors, and delivers the assembled word with a one-cycle valid pulse. It sits between the RX data sampler and the RX output register, replacing separate start/parity/stop check blocks with a single sequencer.

## Interface
- DATA_WIDTH, 8, number of data bits per frame, legal 5..9.
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- edge_det  input  1  one-cycle pulse: falling edge seen on RX line; starts a frame when IDLE.
- bit_vld  input  1  one-cycle pulse: sampled_bit holds the voted value of the current bit period.
- sampled_bit  input  1  voted line value, qualified by bit_vld.
- par_en  input  1  1 = parity bit present.
- par_typ  input  1  0 = even, 1 = odd.
- stop2  input  1  1 = two stop bits, 0 = one.
- data_out  output  DATA_WIDTH  last good received word.
- data_vld  output  1  one-cycle pulse: data_out updated with a good frame.
- strt_glitch  output  1  one-cycle pulse: start bit sampled high.
- par_err  output  1  one-cycle pulse: parity mismatch.
- stp_err  output  1  one-cycle pulse: a stop bit sampled low.
- busy  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: bit_vld is ignored. On edge_det, latch par_en/par_typ/stop2 into shadow registers, clear the bit counter and parity accumulator, and go to START. Config changes mid-frame have no effect.
- START, on bit_vld:
  - sampled_bit=0: go to DATA.
  - sampled_bit=1: pulse strt_glitch and return to IDLE.
- DATA:
  - Each bit_vld shifts sampled_bit in LSB-first, XORs it into the parity accumulator and increments the counter (width $clog2(DATA_WIDTH)).
  - After the DATA_WIDTH-th bit, go to PARITY if shadow par_en is set, else to STOP1.
- PARITY, on bit_vld: the expected bit is accumulator XOR shadow par_typ. On mismatch, pulse par_err and set a sticky bad-frame flag. Always continue to STOP1.
- STOP1, on bit_vld:
  - sampled_bit=0: pulse stp_err and go to IDLE. The frame is discarded.
  - sampled_bit=1 and shadow stop2 set: go to STOP2.
  - sampled_bit=1 and shadow stop2 clear: end the frame.
- STOP2, on bit_vld:
  - sampled_bit=0: pulse stp_err and go to IDLE.
  - sampled_bit=1: end the frame.
- Frame end: if the bad-frame flag is clear, load the shift register into data_out and pulse data_vld. Either way, go to IDLE.
- data_out holds its value until the next good frame. It is never updated on an errored or glitched frame.
- edge_det outside IDLE is ignored. Cycles without bit_vld cause no state change.
- edge_det and bit_vld in the same cycle while IDLE: edge_det acts and bit_vld is ignored. The start bit is the next bit_vld.

## Timing
- Reset values: data_out=0, data_vld=0, strt_glitch=0, par_err=0, stp_err=0, busy=0, state=IDLE, counter=0, flags cleared.
- All outputs are registered. Each pulse asserts in the cycle after the qualifying bit_vld and lasts exactly one CLK.
- busy rises the cycle after edge_det. It falls in the same cycle that data_vld, strt_glitch or stp_err asserts.
- Latency: data_vld appears 1 CLK after the bit_vld of the last stop bit.
- A new edge_det is accepted in the cycle busy is low, i.e. the cycle data_vld is high.
- Reset mid-frame: immediate return to IDLE with all reset values. A pending pulse is not emitted.
- Back-to-back bit_vld on consecutive cycles must be supported: one bit per cycle, no lost samples.

## Test plan
- DATA_WIDTH=8, par_en=1, par_typ=0, stop2=0. Send start 0, data 0xA5 LSB-first, parity 0, stop 1 -> data_out=0xA5, one data_vld pulse, no error pulses, busy low after.
- edge_det, then bit_vld with sampled_bit=1 -> strt_glitch for 1 cycle, busy low, data_out unchanged. A following valid frame of 0x3C is received correctly.
- par_typ=1. Send 0x3C with parity bit 0 and a good stop -> par_err pulse, no data_vld, data_out keeps its previous value.
- stop2=1, par_en=0. Send 0x81 with stop bits 1 then 0 -> stp_err pulse after the second stop, no data_vld. Repeat with stop bits 1,1 -> data_out=0x81 and data_vld.
- Assert RST low during the 4th data bit -> all outputs 0, state IDLE. After release, a full 0x5A frame is received correctly.
- DATA_WIDTH=5, no parity. Send 0x15 with bit_vld on consecutive cycles and edge_det coincident with a bit_vld in IDLE -> data_out=0x15, data_vld asserted.
